alu_74382: RTL and testbench

ALU_74382 -- requirements
Module: alu_74382

---
 rtl/alu_74382_pkg.sv | 60 ++++++
 rtl/alu_74382_adder.sv | 21 ++
 rtl/alu_74382.sv | 116 +++++++++++
 tb/tb_alu_74382.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/alu_74382_pkg.sv
// alu_74382_pkg: shared types, select encoding and reference constants for the 74382-style ALU.
package alu_74382_pkg;

    localparam int SELECT_W         = 3;
    localparam int SEL_MAX          = 8;
    localparam int TB_OPERAND_W     = 4;
    localparam int TB_RESULT_W      = 4;
    localparam int INPUTS_CASES_NUM = 8;
    localparam int CARRY_IDX        = 0;
    localparam int PORT_A_IDX       = 1;
    localparam int PORT_B_IDX       = 2;

    typedef enum logic [SELECT_W-1:0] {
        OP_CLEAR,
        OP_B_MINUS_A,
        OP_A_MINUS_B,
        OP_A_PLUS_B,
        OP_XOR,
        OP_OR,
        OP_AND,
        OP_PRESET
    } op_e;

    typedef struct packed {
        logic                    carry_in;
        logic [TB_OPERAND_W-1:0] port_a;
        logic [TB_OPERAND_W-1:0] port_b;
    } t_inputs;

    typedef struct packed {
        logic [TB_RESULT_W-1:0] result;
        logic                   overflow;
        logic                   carry_out;
    } t_outputs;

    // Rows indexed by sel; columns by case number whose bits pick cin, A=all-x, B=all-x.
    localparam t_outputs expected_table [SEL_MAX][INPUTS_CASES_NUM] = '{
        '{'{4'h0,1'b0,1'b0}, '{4'h0,1'b0,1'b0}, '{4'h0,1'b0,1'b0}, '{4'h0,1'b0,1'b0},
          '{4'h0,1'b0,1'b0}, '{4'h0,1'b0,1'b0}, '{4'h0,1'b0,1'b0}, '{4'h0,1'b0,1'b0}},
        '{'{4'hF,1'b0,1'b0}, '{4'h0,1'b0,1'b1}, '{4'h0,1'b0,1'b0}, '{4'h1,1'b0,1'b0},
          '{4'hE,1'b0,1'b1}, '{4'hF,1'b0,1'b1}, '{4'hF,1'b0,1'b0}, '{4'h0,1'b0,1'b1}},
        '{'{4'hF,1'b0,1'b0}, '{4'h0,1'b0,1'b1}, '{4'hE,1'b0,1'b1}, '{4'hF,1'b0,1'b1},
          '{4'h0,1'b0,1'b0}, '{4'h1,1'b0,1'b0}, '{4'hF,1'b0,1'b0}, '{4'h0,1'b0,1'b1}},
        '{'{4'h0,1'b0,1'b0}, '{4'h1,1'b0,1'b0}, '{4'hF,1'b0,1'b0}, '{4'h0,1'b0,1'b1},
          '{4'hF,1'b0,1'b0}, '{4'h0,1'b0,1'b1}, '{4'hE,1'b0,1'b1}, '{4'hF,1'b0,1'b1}},
        '{'{4'h0,1'b0,1'b0}, '{4'h0,1'b0,1'b0}, '{4'hF,1'b0,1'b0}, '{4'hF,1'b0,1'b0},
          '{4'hF,1'b0,1'b0}, '{4'hF,1'b0,1'b0}, '{4'h0,1'b0,1'b0}, '{4'h0,1'b0,1'b0}},
        '{'{4'h0,1'b0,1'b0}, '{4'h0,1'b0,1'b0}, '{4'hF,1'b0,1'b0}, '{4'hF,1'b0,1'b0},
          '{4'hF,1'b0,1'b0}, '{4'hF,1'b0,1'b0}, '{4'hF,1'b0,1'b0}, '{4'hF,1'b0,1'b0}},
        '{'{4'h0,1'b0,1'b0}, '{4'h0,1'b0,1'b0}, '{4'h0,1'b0,1'b0}, '{4'h0,1'b0,1'b0},
          '{4'h0,1'b0,1'b0}, '{4'h0,1'b0,1'b0}, '{4'hF,1'b0,1'b0}, '{4'hF,1'b0,1'b0}},
        '{'{4'hF,1'b0,1'b0}, '{4'hF,1'b0,1'b0}, '{4'hF,1'b0,1'b0}, '{4'hF,1'b0,1'b0},
          '{4'hF,1'b0,1'b0}, '{4'hF,1'b0,1'b0}, '{4'hF,1'b0,1'b0}, '{4'hF,1'b0,1'b0}}
    };

    function automatic logic [TB_OPERAND_W-1:0] extend_bit(input logic b);
        return {TB_OPERAND_W{b}};
    endfunction

endpackage

// File: rtl/alu_74382_adder.sv
// alu_74382_adder: W-bit adder with carry-in, carry-out and two's-complement overflow.
module alu_74382_adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    logic [W:0] ext;

    assign ext  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign sum  = ext[W-1:0];
    assign cout = ext[W];
    // Carry into the MSB is recovered from the MSB sum bit.
    assign ovf  = (a[W-1] ^ b[W-1] ^ sum[W-1]) ^ cout;

endmodule

// File: rtl/alu_74382.sv
// alu_74382: 8-function ALU with registered outputs (latency 1).
// Define ALU_74382_PIPE_EN to also register the inputs ahead of the core (latency 2).
module alu_74382
    import alu_74382_pkg::*;
#(
    parameter int OPERAND_W = 4,
    parameter int RESULT_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SELECT_W-1:0]  sel,
    input  logic                 carry_in,
    input  logic [OPERAND_W-1:0] port_a,
    input  logic [OPERAND_W-1:0] port_b,
    output logic [RESULT_W-1:0]  result,
    output logic                 overflow,
    output logic                 carry_out
);

    if (RESULT_W != OPERAND_W) begin : g_width_chk
        $error("alu_74382: RESULT_W must equal OPERAND_W");
    end

    logic [SELECT_W-1:0]  sel_c;
    logic                 cin_c;
    logic [OPERAND_W-1:0] a_c, b_c;

`ifdef ALU_74382_PIPE_EN
    logic [SELECT_W-1:0]  sel_q;
    logic                 cin_q;
    logic [OPERAND_W-1:0] a_q, b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= '0;
            cin_q <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            sel_q <= sel;
            cin_q <= carry_in;
            a_q   <= port_a;
            b_q   <= port_b;
        end
    end

    assign sel_c = sel_q;
    assign cin_c = cin_q;
    assign a_c   = a_q;
    assign b_c   = b_q;
`else
    assign sel_c = sel;
    assign cin_c = carry_in;
    assign a_c   = port_a;
    assign b_c   = port_b;
`endif

    op_e                  op;
    logic [OPERAND_W-1:0] add_a, add_b, add_sum;
    logic                 add_cout, add_ovf;
    logic [OPERAND_W:0]   result_ext;

    assign op    = op_e'(sel_c);
    assign add_a = (op == OP_B_MINUS_A) ? ~a_c : a_c;
    assign add_b = (op == OP_A_MINUS_B) ? ~b_c : b_c;

    alu_74382_adder #(.W(OPERAND_W)) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (cin_c),
        .sum  (add_sum),
        .cout (add_cout),
        .ovf  (add_ovf)
    );

    assign result_ext = {add_cout, add_sum};

    logic [RESULT_W-1:0] result_d, result_q;
    logic                overflow_d, overflow_q;
    logic                carry_d, carry_q;

    always_comb begin
        result_d   = '0;
        overflow_d = 1'b0;
        carry_d    = 1'b0;
        case (op)
            OP_B_MINUS_A, OP_A_MINUS_B, OP_A_PLUS_B: begin
                result_d   = result_ext[OPERAND_W-1:0];
                carry_d    = result_ext[OPERAND_W];
                overflow_d = add_ovf;
            end
            OP_XOR:    result_d = a_c ^ b_c;
            OP_OR:     result_d = a_c | b_c;
            OP_AND:    result_d = a_c & b_c;
            OP_PRESET: result_d = '1;
            default:   result_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q   <= '0;
            overflow_q <= 1'b0;
            carry_q    <= 1'b0;
        end else begin
            result_q   <= result_d;
            overflow_q <= overflow_d;
            carry_q    <= carry_d;
        end
    end

    assign result    = result_q;
    assign overflow  = overflow_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_alu_74382.sv
// tb_alu_74382: randomized and directed checking of alu_74382 against an arithmetic reference model.
module tb_alu_74382;
    import alu_74382_pkg::*;

    localparam int W = TB_OPERAND_W;
`ifdef ALU_74382_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic [SELECT_W-1:0] sel;
    logic                carry_in;
    logic [W-1:0]        port_a, port_b;
    logic [W-1:0]        result;
    logic                overflow, carry_out;

    int checks   = 0;
    int failures = 0;

    alu_74382 #(.OPERAND_W(W), .RESULT_W(TB_RESULT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (sel),
        .carry_in  (carry_in),
        .port_a    (port_a),
        .port_b    (port_b),
        .result    (result),
        .overflow  (overflow),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic; overflow judged by signed range.
    function automatic t_outputs model(input logic [2:0] s, input logic ci,
                                       input logic [W-1:0] a, input logic [W-1:0] b);
        int x, y, full, sx, sy, ssum;
        int m;
        t_outputs o;
        m = 1 << W;
        o = '0;
        x = 0;
        y = 0;
        case (s)
            3'd1: begin x = int'(b); y = m - 1 - int'(a); end
            3'd2: begin x = int'(a); y = m - 1 - int'(b); end
            3'd3: begin x = int'(a); y = int'(b); end
            default: ;
        endcase
        if (s inside {3'd1, 3'd2, 3'd3}) begin
            full        = x + y + int'(ci);
            o.result    = W'(full % m);
            o.carry_out = (full >= m);
            sx          = (x >= m / 2) ? x - m : x;
            sy          = (y >= m / 2) ? y - m : y;
            ssum        = sx + sy + int'(ci);
            o.overflow  = (ssum > m / 2 - 1) || (ssum < -(m / 2));
        end else if (s == 3'd4) o.result = a ^ b;
        else if (s == 3'd5) o.result = a | b;
        else if (s == 3'd6) o.result = a & b;
        else if (s == 3'd7) o.result = '1;
        return o;
    endfunction

    task automatic check(input string name, input t_outputs act, input t_outputs exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got result=%h ovf=%b cout=%b, want result=%h ovf=%b cout=%b",
                     name, act.result, act.overflow, act.carry_out,
                     exp.result, exp.overflow, exp.carry_out);
        end
    endtask

    function automatic t_outputs dut_out();
        return {result, overflow, carry_out};
    endfunction

    t_outputs exp_pipe [LAT] = '{default: '0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) exp_pipe[i] <= '0;
        end else begin
            exp_pipe[0] <= model(sel, carry_in, port_a, port_b);
            for (int i = 1; i < LAT; i++) exp_pipe[i] <= exp_pipe[i-1];
        end
    end

    always @(negedge clk) check("cycle", dut_out(), exp_pipe[LAT-1]);

    task automatic run_op(input string name, input logic [2:0] s, input logic ci,
                          input logic [W-1:0] a, input logic [W-1:0] b, input t_outputs exp);
        sel      = s;
        carry_in = ci;
        port_a   = a;
        port_b   = b;
        repeat (LAT) @(posedge clk);
        #1 check(name, dut_out(), exp);
    endtask

    initial begin
        logic [2:0] c;
        rst_n    = 1'b0;
        sel      = '0;
        carry_in = 1'b0;
        port_a   = '0;
        port_b   = '0;
        #2 check("reset_state", dut_out(), '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_op("add_max",     3'b011, 1'b1, 4'hF, 4'hF, '{4'hF, 1'b0, 1'b1});
        run_op("add_ovf",     3'b011, 1'b0, 4'h7, 4'h1, '{4'h8, 1'b1, 1'b0});
        run_op("a_minus_b",   3'b010, 1'b1, 4'h0, 4'hF, '{4'h1, 1'b0, 1'b0});
        run_op("b_minus_a",   3'b001, 1'b1, 4'h0, 4'hF, '{4'hF, 1'b0, 1'b1});
        run_op("sub_noborrow",3'b010, 1'b1, 4'h5, 4'h3, '{4'h2, 1'b0, 1'b1});
        run_op("clear",       3'b000, 1'b1, 4'hA, 4'h5, '{4'h0, 1'b0, 1'b0});
        run_op("preset",      3'b111, 1'b1, 4'h3, 4'hC, '{4'hF, 1'b0, 1'b0});
        run_op("xor",         3'b100, 1'b0, 4'hF, 4'h0, '{4'hF, 1'b0, 1'b0});
        check("model_pin_ovf", model(3'b011, 1'b0, 4'h7, 4'h1), '{4'h8, 1'b1, 1'b0});
        check("model_pin_sub", model(3'b001, 1'b1, 4'h3, 4'h5), '{4'h2, 1'b0, 1'b1});

        for (int s = 0; s < SEL_MAX; s++) begin
            for (int k = 0; k < INPUTS_CASES_NUM; k++) begin
                c = 3'(k);
                check("model_table", model(3'(s), c[CARRY_IDX], extend_bit(c[PORT_A_IDX]),
                      extend_bit(c[PORT_B_IDX])), expected_table[s][k]);
                run_op("sweep", 3'(s), c[CARRY_IDX], extend_bit(c[PORT_A_IDX]),
                       extend_bit(c[PORT_B_IDX]), expected_table[s][k]);
            end
        end

        for (int i = 0; i < 400; i++) begin
            sel      = 3'($urandom_range(0, 7));
            carry_in = 1'($urandom_range(0, 1));
            port_a   = W'($urandom);
            port_b   = W'($urandom);
            @(posedge clk);
            #1;
        end

        run_op("preset_pre_rst", 3'b111, 1'b0, 4'h0, 4'h0, '{4'hF, 1'b0, 1'b0});
        #2 rst_n = 1'b0;
        #1 check("async_reset", dut_out(), '0);
        @(posedge clk);
        #1 check("reset_held", dut_out(), '0);
        rst_n = 1'b1;
        repeat (LAT) @(posedge clk);
        #1 check("after_reset", dut_out(), '{4'hF, 1'b0, 1'b0});

        repeat (3) @(posedge clk);
        #1 $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
